// File: rtl/interpolator_pkg.sv
// Shared FSM encoding and width helpers for the power-of-two interpolator.
package interpolator_pkg;

    typedef logic [1:0] state_t;

    localparam state_t STATE_PRIME = 2'd0;
    localparam state_t STATE_IDLE  = 2'd1;
    localparam state_t STATE_EMIT  = 2'd2;

    // The extra bit keeps previous*N + k*delta exact for every k < N.
    function automatic int accumulator_width(input int word_width, input int exponent);
        return word_width + exponent + 1;
    endfunction

endpackage

// File: rtl/interpolator_step_datapath.sv
// Delta/accumulator datapath of the interpolator, driven by prime/load/step/finish strobes.
// Macro INTERPOLATOR_ROUND_NEAREST_EN selects round-half-up instead of floor.
module interpolator_step_datapath
    import interpolator_pkg::*;
#(
    parameter int WORD_WIDTH            = 16,
    parameter int POWER_OF_TWO_EXPONENT = 2
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  prime,
    input  logic                  load,
    input  logic                  step,
    input  logic                  finish,
    input  logic [WORD_WIDTH-1:0] sample,
    output logic [WORD_WIDTH-1:0] output_sample
);

    localparam int E         = POWER_OF_TWO_EXPONENT;
    localparam int ACC_WIDTH = accumulator_width(WORD_WIDTH, E);

    logic [WORD_WIDTH-1:0] previous;
    logic [WORD_WIDTH-1:0] current;
    logic [WORD_WIDTH:0]   delta;
    logic [ACC_WIDTH-1:0]  accumulator;
    logic [ACC_WIDTH-1:0]  accumulator_next;
    logic signed [ACC_WIDTH-1:0] rounded;
    logic signed [ACC_WIDTH-1:0] scaled;
    logic [WORD_WIDTH:0]   unused_scaled_msbs;

    // NOTE: every variable written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        accumulator_next = accumulator + {{E{delta[WORD_WIDTH]}}, delta};
`ifdef INTERPOLATOR_ROUND_NEAREST_EN
        rounded = accumulator_next + (ACC_WIDTH'(1) << (E - 1));
`else
        rounded = accumulator_next;
`endif
        scaled = rounded >>> E;
    end

    // Results always lie between previous and current, so the dropped bits are pure sign extension.
    assign unused_scaled_msbs = scaled[ACC_WIDTH-1:WORD_WIDTH];

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            previous      <= '0;
            current       <= '0;
            delta         <= '0;
            accumulator   <= '0;
            output_sample <= '0;
        end else if (prime) begin
            previous <= sample;
        end else if (load) begin
            current       <= sample;
            delta         <= {sample[WORD_WIDTH-1], sample} - {previous[WORD_WIDTH-1], previous};
            accumulator   <= {previous[WORD_WIDTH-1], previous, {E{1'b0}}};
            output_sample <= previous;
        end else if (step) begin
            accumulator   <= accumulator_next;
            output_sample <= scaled[WORD_WIDTH-1:0];
        end else if (finish) begin
            accumulator <= accumulator_next;
            previous    <= current;
        end
    end

endmodule

// File: rtl/interpolator_powers_of_two.sv
// Upsamples a signed stream by 2^POWER_OF_TWO_EXPONENT with shift/add linear interpolation.
// Optional macro INTERPOLATOR_ROUND_NEAREST_EN (in the datapath) rounds half-up instead of flooring.
module interpolator_powers_of_two
    import interpolator_pkg::*;
#(
    parameter int WORD_WIDTH            = 16,
    parameter int POWER_OF_TWO_EXPONENT = 2
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  restart_interpolation,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [WORD_WIDTH-1:0] input_sample,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [WORD_WIDTH-1:0] output_sample
);

    localparam int E = POWER_OF_TWO_EXPONENT;

    if (POWER_OF_TWO_EXPONENT < 1) begin : gen_exponent_check
        $error("POWER_OF_TWO_EXPONENT must be at least 1");
    end

    localparam logic [E-1:0] LAST_STEP = '1;

    state_t       state;
    state_t       state_next;
    logic [E-1:0] step_count;
    logic         restart_previous;
    logic         restart_pulse;
    logic         input_fire;
    logic         output_fire;
    logic         last_step;

    assign restart_pulse = restart_interpolation && !restart_previous;
    assign input_fire    = input_valid && input_ready;
    assign output_fire   = output_valid && output_ready && (state == STATE_EMIT);
    assign last_step     = (step_count == LAST_STEP);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state            <= STATE_PRIME;
            restart_previous <= 1'b0;
        end else begin
            state            <= state_next;
            restart_previous <= restart_interpolation;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            STATE_PRIME: if (input_fire) state_next = STATE_IDLE;
            STATE_IDLE:  if (input_fire) state_next = STATE_EMIT;
            STATE_EMIT:  if (output_fire && last_step) state_next = STATE_IDLE;
            default:     state_next = STATE_PRIME;
        endcase
        if (restart_pulse) state_next = STATE_PRIME;
    end

    // A restart edge blocks the input side in the same cycle it is seen.
    always_comb begin
        input_ready = ((state == STATE_PRIME) || (state == STATE_IDLE)) && !restart_pulse;
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            output_valid <= 1'b0;
            step_count   <= '0;
        end else if (restart_pulse) begin
            output_valid <= 1'b0;
            step_count   <= '0;
        end else if (input_fire && (state == STATE_IDLE)) begin
            output_valid <= 1'b1;
            step_count   <= '0;
        end else if (output_fire) begin
            step_count <= step_count + 1'b1;
            if (last_step) output_valid <= 1'b0;
        end
    end

    interpolator_step_datapath #(
        .WORD_WIDTH            (WORD_WIDTH),
        .POWER_OF_TWO_EXPONENT (POWER_OF_TWO_EXPONENT)
    ) u_datapath (
        .clock         (clock),
        .clear_n       (clear_n),
        .prime         (input_fire && (state == STATE_PRIME)),
        .load          (input_fire && (state == STATE_IDLE)),
        .step          (output_fire && !last_step),
        .finish        (output_fire && last_step),
        .sample        (input_sample),
        .output_sample (output_sample)
    );

endmodule

// File: tb/tb_interpolator_powers_of_two.sv
// Randomised bench for interpolator_powers_of_two against an arithmetic reference queue.
module tb_interpolator_powers_of_two;

    localparam int W = 16;
    localparam int E = 2;
    localparam longint N = longint'(1) << E;

    logic         clock = 1'b0;
    logic         clear_n = 1'b0;
    logic         restart_interpolation = 1'b0;
    logic         input_valid = 1'b0;
    logic         input_ready;
    logic [W-1:0] input_sample = '0;
    logic         output_valid;
    logic         output_ready = 1'b0;
    logic [W-1:0] output_sample;

    int compared_count = 0;
    int mismatch_count = 0;

    longint expected_q[$];
    bit     primed = 1'b0;
    longint prev_value = 0;
    bit     restart_last = 1'b0;
    bit     last_in_fire = 1'b0;
    int     ready_phase = 0;

    interpolator_powers_of_two #(
        .WORD_WIDTH            (W),
        .POWER_OF_TWO_EXPONENT (E)
    ) dut (
        .clock                 (clock),
        .clear_n               (clear_n),
        .restart_interpolation (restart_interpolation),
        .input_valid           (input_valid),
        .input_ready           (input_ready),
        .input_sample          (input_sample),
        .output_valid          (output_valid),
        .output_ready          (output_ready),
        .output_sample         (output_sample)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input longint actual, input longint expected);
        compared_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint n);
        longint q;
        q = a / n;
        if ((a % n != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Interval p -> c yields N points on the line from p towards c, scaled back by N.
    function automatic void model_accept(input longint s);
        longint d;
        longint bias;
        if (!primed) begin
            prev_value = s;
            primed     = 1'b1;
        end else begin
            d = s - prev_value;
`ifdef INTERPOLATOR_ROUND_NEAREST_EN
            bias = N / 2;
`else
            bias = 0;
`endif
            for (longint k = 0; k < N; k++)
                expected_q.push_back(floor_div(prev_value * N + k * d + bias, N));
            prev_value = s;
        end
    endfunction

    function automatic bit ready_for(input int mode);
        bit r;
        case (mode)
            0:       r = 1'b1;
            1:       r = (ready_phase % 3 == 0);
            default: r = ($urandom_range(0, 3) != 0);
        endcase
        ready_phase++;
        return r;
    endfunction

    task automatic cycle(input bit valid, input logic [W-1:0] sample, input bit ready, input bit restart);
        bit restart_edge;
        @(negedge clock);
        input_valid           = valid;
        input_sample          = sample;
        output_ready          = ready;
        restart_interpolation = restart;
        #1;
        restart_edge = restart && !restart_last;
        restart_last = restart;
        check("output_valid", longint'(output_valid), longint'(expected_q.size() != 0));
        check("input_ready", longint'(input_ready), longint'((expected_q.size() == 0) && !restart_edge));
        if (output_valid && expected_q.size() != 0)
            check("output_sample", longint'($signed(output_sample)), expected_q[0]);
        if (output_valid && output_ready && expected_q.size() != 0)
            void'(expected_q.pop_front());
        last_in_fire = input_valid && input_ready;
        if (restart_edge) begin
            expected_q.delete();
            primed = 1'b0;
        end else if (last_in_fire) begin
            model_accept(longint'($signed(input_sample)));
        end
    endtask

    task automatic send(input logic [W-1:0] sample, input int mode);
        bit accepted = 1'b0;
        for (int i = 0; i < 64 && !accepted; i++) begin
            cycle(1'b1, sample, ready_for(mode), restart_last);
            accepted = last_in_fire;
        end
        if (!accepted) check("send_timeout", 0, 1);
    endtask

    task automatic drain(input int cycles, input int mode);
        for (int i = 0; i < cycles; i++) cycle(1'b0, '0, ready_for(mode), restart_last);
    endtask

    task automatic do_clear();
        @(negedge clock);
        clear_n = 1'b0;
        #1;
        check("clear_output_valid", longint'(output_valid), 0);
        check("clear_input_ready", longint'(input_ready), 1);
        check("clear_output_sample", longint'(output_sample), 0);
        expected_q.delete();
        primed                = 1'b0;
        restart_last          = 1'b0;
        input_valid           = 1'b0;
        restart_interpolation = 1'b0;
        @(negedge clock);
        clear_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("reset_output_valid", longint'(output_valid), 0);
        check("reset_input_ready", longint'(input_ready), 1);
        check("reset_output_sample", longint'(output_sample), 0);
        clear_n = 1'b1;

        // Ramp 0, 8, 12 with the consumer always ready.
        send(16'd0, 0);
        send(16'd8, 0);
        send(16'd12, 0);
        drain(8, 0);

        // Negative slope, where floor and round-half-up differ.
        do_clear();
        send(16'd0, 0);
        send(-16'sd3, 0);
        drain(8, 0);

        // Consumer stalls in a 1,0,0 pattern.
        do_clear();
        send(16'd0, 1);
        send(16'd8, 1);
        drain(16, 1);

        // Restart after the second output, then hold restart high while re-priming.
        do_clear();
        send(16'd0, 0);
        send(16'd8, 0);
        drain(2, 0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        send(16'd20, 0);
        send(16'd24, 0);
        drain(8, 0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Full-scale swings must not wrap.
        do_clear();
        send(16'h7fff, 0);
        send(16'h8000, 0);
        send(16'h7fff, 2);
        drain(12, 2);

        // Clear in the middle of an interval; the next input only primes.
        do_clear();
        send(16'd100, 0);
        send(16'd200, 0);
        drain(1, 0);
        do_clear();
        send(16'd5, 0);
        drain(6, 0);

        // Random traffic with stalls and occasional restart edges.
        do_clear();
        for (int i = 0; i < 3000; i++) begin
            bit restart_level = restart_last;
            if ($urandom_range(0, 39) == 0) restart_level = !restart_level;
            cycle(bit'($urandom_range(0, 1)), W'($urandom), ready_for(2), restart_level);
        end
        drain(20, 0);
        check("queue_drained", longint'(expected_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_count, mismatch_count);
        $finish;
    end

endmodule
